// File: rtl/signed_add_arbiter_pkg.sv
// Shared constants and helpers for the signed_add_arbiter block.
//   N_REQ_DEF / W_DEF / CNT_W_DEF : default requester count, operand width, counter width
//   id_width()                    : width of an encoded requester index (at least 1 bit)
package signed_add_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 4;
  localparam int unsigned CNT_W_DEF = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/signed_add_arbiter_if.sv
// Request/response bundle between arithmetic clients and the shared adder.
//   req_valid/req_ready : per-requester request handshake (ready is one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   res_valid/res_ready : result handshake
//   res_sum/res_overflow/res_id : result payload
//   ovf_count           : saturating count of overflowed results
// Modport master = client/consumer side, slave = adder block side.
interface signed_add_arbiter_if
  import signed_add_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  localparam int unsigned ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [W-1:0]       res_sum;
  logic               res_overflow;
  logic [ID_W-1:0]    res_id;
  logic [CNT_W-1:0]   ovf_count;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_overflow, res_id, ovf_count
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_overflow, res_id, ovf_count
  );

endinterface

// File: rtl/signed_add_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index with highest priority this cycle
//   en      : when low, no grant is issued (gnt is all zero)
//   gnt     : one-hot grant (zero when en is low or nothing requests)
//   gnt_idx : encoded index of the winner (valid whenever any req bit is set)
module rr_arbiter
  import signed_add_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]           req,
  input  logic [id_width(N_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [N_REQ-1:0]           gnt,
  output logic [id_width(N_REQ)-1:0] gnt_idx
);
  localparam int unsigned ID_W = id_width(N_REQ);

  logic        found;
  int unsigned idx;

  // Scan starting at ptr, wrapping modulo N_REQ; first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = en;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/signed_add_arbiter.sv
// Shared W-bit two's-complement adder with round-robin access for N_REQ requesters.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : request/response bundle (slave side), see signed_add_arbiter_if
// A single registered result slot is refilled whenever it is empty or being drained,
// giving one result per cycle under continuous demand.
module signed_add_arbiter
  import signed_add_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  signed_add_arbiter_if.slave bus
);
  localparam int unsigned ID_W = id_width(N_REQ);

  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_nxt;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             can_accept;
  logic             arb_en;
  logic             accept;

  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     sum;
  logic             ovf;

  logic             res_valid_q;
  logic [W-1:0]     res_sum_q;
  logic             res_ovf_q;
  logic [ID_W-1:0]  res_id_q;
  logic [CNT_W-1:0] ovf_cnt_q;

  // Slot is free if empty or the consumer takes it this cycle.
  assign can_accept = !res_valid_q || bus.res_ready;
  // No grants are offered while reset is asserted.
  assign arb_en     = can_accept && !rst;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept        = |gnt;
  assign bus.req_ready = gnt;

  assign op_a = bus.req_a[32'(gnt_idx) * W +: W];
  assign op_b = bus.req_b[32'(gnt_idx) * W +: W];
  assign sum  = op_a + op_b;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign ovf  = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);

  assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      if (accept) begin
        ptr_q       <= ptr_nxt;
        res_valid_q <= 1'b1;
        res_sum_q   <= sum;
        res_ovf_q   <= ovf;
        res_id_q    <= gnt_idx;
        if (ovf && (ovf_cnt_q != '1)) begin
          ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
        end
      end else if (bus.res_ready) begin
        // Drained with no refill; payload fields are left stale.
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.res_valid    = res_valid_q;
  assign bus.res_sum      = res_sum_q;
  assign bus.res_overflow = res_ovf_q;
  assign bus.res_id       = res_id_q;
  assign bus.ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed-vector bench for signed_add_arbiter with a result scoreboard.
module tb_signed_add_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned WD = 4;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [3:0] sum;
    logic       ovf;
    logic [1:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  signed_add_arbiter_if #(.N_REQ(NR), .W(WD), .CNT_W(CW)) bus ();

  signed_add_arbiter #(
    .N_REQ (NR),
    .W     (WD),
    .CNT_W (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane(input int i, input logic [3:0] v);
    return 16'(v) << (4 * i);
  endfunction

  // Drive one cycle of stimulus (called at posedge+1), check req_ready at the
  // negedge, and queue the expected result if a grant is expected.
  task automatic step(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                      input logic rdy, input logic [3:0] exp_rdy, input logic [3:0] es,
                      input logic eo, input string name);
    exp_t e;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.res_ready = rdy;
    @(negedge clk);
    chk({name, ".req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) begin
      e.sum = es;
      e.ovf = eo;
      e.id  = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) e.id = 2'(i);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every consumed result is compared with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d sum 0x%0h, expected no result",
                   bus.res_id, bus.res_sum);
        end else begin
          e = exp_q.pop_front();
          chk("res_sum", 32'(bus.res_sum), 32'(e.sum));
          chk("res_overflow", 32'(bus.res_overflow), 32'(e.ovf));
          chk("res_id", 32'(bus.res_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;

    // Reset held two cycles with all requesters asking.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst.req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst.res_valid", 32'(bus.res_valid), 32'h0);
      chk("rst.ovf_count", 32'(bus.ovf_count), 32'h0);
    end
    rst = 1'b0;

    // Round robin from pointer 0, every lane 1+1.
    step(4'b1111, 16'h1111, 16'h1111, 1'b1, 4'b0001, 4'h2, 1'b0, "rr0");
    step(4'b1111, 16'h1111, 16'h1111, 1'b1, 4'b0010, 4'h2, 1'b0, "rr1");
    chk("rr.res_valid", 32'(bus.res_valid), 32'h1);
    step(4'b1111, 16'h1111, 16'h1111, 1'b1, 4'b0100, 4'h2, 1'b0, "rr2");
    chk("rr.res_valid", 32'(bus.res_valid), 32'h1);
    step(4'b1111, 16'h1111, 16'h1111, 1'b1, 4'b1000, 4'h2, 1'b0, "rr3");
    chk("rr.res_valid", 32'(bus.res_valid), 32'h1);
    step(4'b1111, 16'h1111, 16'h1111, 1'b1, 4'b0001, 4'h2, 1'b0, "rr4");
    step(4'b1111, 16'h1111, 16'h1111, 1'b1, 4'b0010, 4'h2, 1'b0, "rr5");
    chk("rr.res_valid", 32'(bus.res_valid), 32'h1);

    // Single request: 3 + (-5) = -2.
    step(4'b0010, lane(1, 4'h3), lane(1, 4'hB), 1'b1, 4'b0010, 4'hE, 1'b0, "single");
    chk("single.res_valid", 32'(bus.res_valid), 32'h1);

    // Overflow sequence on requester 2.
    step(4'b0100, lane(2, 4'h7), lane(2, 4'h4), 1'b1, 4'b0100, 4'hB, 1'b1, "ovf_7p4");
    chk("ovf.count1", 32'(bus.ovf_count), 32'd1);
    step(4'b0100, lane(2, 4'hC), lane(2, 4'h9), 1'b1, 4'b0100, 4'h5, 1'b1, "ovf_m4m7");
    step(4'b0100, lane(2, 4'hC), lane(2, 4'hC), 1'b1, 4'b0100, 4'h8, 1'b0, "ovf_m4m4");
    step(4'b0100, lane(2, 4'h4), lane(2, 4'hC), 1'b1, 4'b0100, 4'h0, 1'b0, "ovf_4m4");
    chk("ovf.count2", 32'(bus.ovf_count), 32'd2);

    // Drain with no new request.
    step(4'b0000, 16'h0, 16'h0, 1'b1, 4'b0000, 4'h0, 1'b0, "drain");
    chk("drain.res_valid", 32'(bus.res_valid), 32'h0);

    // Backpressure: 2+1 held for three cycles.
    step(4'b0100, lane(2, 4'h2), lane(2, 4'h1), 1'b0, 4'b0100, 4'h3, 1'b0, "bp_load");
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, lane(2, 4'h2), lane(2, 4'h1), 1'b0, 4'b0000, 4'h0, 1'b0, "bp_hold");
      chk("bp.res_valid", 32'(bus.res_valid), 32'h1);
      chk("bp.res_sum", 32'(bus.res_sum), 32'h3);
    end
    step(4'b0100, lane(2, 4'h2), lane(2, 4'h1), 1'b1, 4'b0100, 4'h3, 1'b0, "bp_release");
    chk("bp.release_valid", 32'(bus.res_valid), 32'h1);

    // Saturation: 300 x (7+7) on requester 0.
    for (int i = 0; i < 300; i++) begin
      step(4'b0001, lane(0, 4'h7), lane(0, 4'h7), 1'b1, 4'b0001, 4'hE, 1'b1, "sat");
    end
    step(4'b0000, 16'h0, 16'h0, 1'b1, 4'b0000, 4'h0, 1'b0, "sat_drain");
    chk("sat.ovf_count", 32'(bus.ovf_count), 32'd255);

    // Clear, then build res_valid=1, pointer=2, ovf_count=5.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("clr.ovf_count", 32'(bus.ovf_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, lane(1, 4'h7), lane(1, 4'h7), 1'b1, 4'b0010, 4'hE, 1'b1, "pre_rst");
    end
    chk("pre_rst.ovf_count", 32'(bus.ovf_count), 32'd5);
    chk("pre_rst.res_valid", 32'(bus.res_valid), 32'h1);

    // Reset mid-operation; the in-flight result is discarded.
    rst           = 1'b1;
    bus.req_valid = 4'b0101;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("midrst.req_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("midrst.res_valid", 32'(bus.res_valid), 32'h0);
    chk("midrst.ovf_count", 32'(bus.ovf_count), 32'd0);
    rst = 1'b0;
    step(4'b0101, lane(0, 4'h1) | lane(2, 4'h1), lane(0, 4'h1) | lane(2, 4'h1), 1'b1,
         4'b0001, 4'h2, 1'b0, "post_rst0");
    step(4'b0101, lane(0, 4'h1) | lane(2, 4'h1), lane(0, 4'h1) | lane(2, 4'h1), 1'b1,
         4'b0100, 4'h2, 1'b0, "post_rst2");
    step(4'b0000, 16'h0, 16'h0, 1'b1, 4'b0000, 4'h0, 1'b0, "final_drain");
    step(4'b0000, 16'h0, 16'h0, 1'b1, 4'b0000, 4'h0, 1'b0, "idle");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_add_arbiter.md
Name: signed_add_arbiter

Overview:
- Shares one W-bit two's-complement adder with overflow detection between N_REQ requesters.
- Each requester uses a valid/ready request channel. A round-robin arbiter grants one requester per cycle.
- The single-entry output register returns sum, overflow flag and requester id over a valid/ready response channel.
- A saturating counter tracks overflow events. The block sits between arithmetic clients and the shared adder datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W, 4, operand/sum width in bits.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  N_REQ*W  operand a; slice i = bits [i*W +: W].
- req_b  input  N_REQ*W  operand b; same packing.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts result.
- res_sum  output  W  sum, low W bits of a+b.
- res_overflow  output  1  signed overflow of that sum.
- res_id  output  $clog2(N_REQ)  index of requester that produced the result.
- ovf_count  output  CNT_W  number of overflowed results accepted, saturating.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following; rst overrides any in-flight transfer:
  - res_valid=0, res_sum=0, res_overflow=0, res_id=0.
  - ovf_count=0.
  - round-robin pointer=0, so requester 0 has highest priority.
- Handshakes:
  - Accept condition: can_accept = !res_valid || res_ready.
  - req_ready is combinational from req_valid, pointer and can_accept.
  - req_ready[i]=1 only for the granted requester, and only when can_accept.
  - Requesters must not make valid depend on ready.
  - Requesters must hold a/b stable while valid && !ready.
- Arbitration:
  - Among asserted req_valid, grant the first index at or after the pointer, wrapping modulo N_REQ.
  - On an accept from requester g, the pointer becomes (g+1) mod N_REQ. Wrap from N_REQ-1 goes to 0.
  - The pointer is unchanged when there is no accept.
- Datapath, computed on the granted operands:
  - sum = (a+b) mod 2^W.
  - overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
- Latency: an accept in cycle t gives res_valid=1 in cycle t+1, with res_sum/res_overflow/res_id loaded at the same edge.
- Backpressure: while res_valid && !res_ready, all req_ready=0 and the result outputs are held stable.
- Simultaneous drain and accept: when res_valid && res_ready and a request is granted in the same cycle, the new result replaces the old one at that edge. res_valid stays 1, giving a throughput of 1 result/cycle.
- When the result drains with no new grant, res_valid goes to 0 at the next edge. The result fields keep their stale values (don't-care).
- ovf_count increments at the edge where a result with res_overflow=1 is loaded. It holds at 2^CNT_W-1 and never wraps.
- No requests: pointer, counter and result register are unchanged.

Decomposition:
- Package signed_add_arbiter_pkg holds:
  - default constants N_REQ_DEF=4, W_DEF=4, CNT_W_DEF=8.
  - the localparam formula for id width.
- One sub-module is natural: rr_arbiter (N_REQ), a pure combinational unit.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded grant index.
  - The pointer register stays in the top module.
- The adder and the overflow logic stay inline in the top module.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=4'b1111 -> req_ready=0 during reset, res_valid=0, ovf_count=0. The first post-reset grant goes to requester 0.
- Single request: requester 1 with a=3, b=-5 (4'hB), res_ready=1 -> req_ready=4'b0010 that cycle. Next cycle res_valid=1, res_sum=4'hE (-2), res_overflow=0, res_id=1.
- Round robin: req_valid=4'b1111 held, res_ready=1, all requesters a=1, b=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles. res_id follows one cycle later; res_valid stays 1 continuously.
- Overflow and counter: the following requests in sequence, with ovf_count=2 after all four are accepted:
  - 7+4 -> sum 4'hB, ovf=1.
  - -4+-7 -> sum 4'h5, ovf=1.
  - -4+-4 -> sum 4'h8, ovf=0.
  - 4+-4 -> sum 0, ovf=0.
  Additionally, 300 consecutive 7+7 requests -> ovf_count saturates at 255.
- Backpressure: result 2+1 valid, res_ready=0 for 3 cycles with req_valid=4'b0100 -> req_ready=0 and res_sum=3 held stable. Raise res_ready -> same-cycle accept of requester 2 and a new result next cycle, with res_valid never dropping.
- Reset mid-operation: assert rst while res_valid=1, pointer=2, ovf_count=5 -> next cycle res_valid=0, ovf_count=0, pointer=0. The pointer reset is shown by requester 0 being granted before requester 2 when both request.
